// File: rtl/key_loader_pkg.sv
// Shared types and sizing helpers for the key stream loader.
package key_loader_pkg;

    localparam int unsigned CHECKSUM_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHK,
        ACTIVE,
        ERROR,
        LOCKOUT
    } state_e;

    function automatic int unsigned nchunk(input int unsigned key_w, input int unsigned chunk_w);
        return key_w / chunk_w;
    endfunction

endpackage

// File: rtl/key_stream_loader_if.sv
// Valid/ready chunk stream carrying key chunks and the trailing checksum chunk.
interface key_stream_loader_if
    import key_loader_pkg::*;
#(
    parameter int unsigned CHUNK_W = CHECKSUM_W
);
    logic               in_valid;
    logic [CHUNK_W-1:0] in_data;
    logic               in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/key_chunk_shifter.sv
// MSB-first chunk shift register with running XOR checksum and chunk counter.
module key_chunk_shifter
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_W   = 16,
    parameter int unsigned CHUNK_W = CHECKSUM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift_en,
    input  logic [CHUNK_W-1:0] din,
    output logic [KEY_W-1:0]   key,
    output logic [CHUNK_W-1:0] acc,
    output logic               done_c
);
    localparam int unsigned NCHUNK = nchunk(KEY_W, CHUNK_W);
    localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            key <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            key <= (key << CHUNK_W) | KEY_W'(din);
            acc <= acc ^ din;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // High while the next accepted chunk is the last key chunk.
    assign done_c = (cnt == CNT_W'(NCHUNK - 1));

endmodule

// File: rtl/key_stream_loader.sv
// Key delivery front end: assembles streamed key chunks, verifies the XOR checksum,
// and exposes the key only once verified. Define KEY_LOCKOUT_EN for failed-load lockout.
module key_stream_loader
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned CHUNK_W  = CHECKSUM_W,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_start,
    key_stream_loader_if.slave        stream,
    output logic [KEY_W-1:0]          key_out,
    output logic                      key_valid,
    output logic                      load_err,
    output logic                      busy
);
    if ((KEY_W % CHUNK_W) != 0 || KEY_W < CHUNK_W || MAX_FAIL == 0) begin : g_cfg_err
        $error("key_stream_loader: KEY_W must be a multiple of CHUNK_W and MAX_FAIL nonzero");
    end

    state_e             state;
    logic               in_ready_q;
    logic [KEY_W-1:0]   sh_key;
    logic [CHUNK_W-1:0] sh_acc;
    logic               sh_done_c;
    logic               accept_c;
    logic               restart_c;
    logic               shift_c;

`ifdef KEY_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
    logic [FAIL_W-1:0] fail_cnt;
    logic              lock_c;

    // This failure is the one that exhausts the allowance.
    assign lock_c    = (fail_cnt == FAIL_W'(MAX_FAIL - 1));
    assign restart_c = load_start && (state != LOCKOUT);
`else
    assign restart_c = load_start;
`endif

    assign stream.in_ready = in_ready_q;
    assign accept_c        = stream.in_valid && in_ready_q;
    assign shift_c         = accept_c && !restart_c && (state == LOAD);

    key_chunk_shifter #(
        .KEY_W   (KEY_W),
        .CHUNK_W (CHUNK_W)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (restart_c),
        .shift_en (shift_c),
        .din      (stream.in_data),
        .key      (sh_key),
        .acc      (sh_acc),
        .done_c   (sh_done_c)
    );

    // Control FSM; a restart overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_out    <= '0;
            key_valid  <= 1'b0;
            load_err   <= 1'b0;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
`ifdef KEY_LOCKOUT_EN
            fail_cnt   <= '0;
`endif
        end else if (restart_c) begin
            state      <= LOAD;
            key_out    <= '0;
            key_valid  <= 1'b0;
            load_err   <= 1'b0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (accept_c && sh_done_c) begin
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (accept_c) begin
                        in_ready_q <= 1'b0;
                        busy       <= 1'b0;
                        if (stream.in_data == sh_acc) begin
                            state     <= ACTIVE;
                            key_out   <= sh_key;
                            key_valid <= 1'b1;
`ifdef KEY_LOCKOUT_EN
                            fail_cnt  <= '0;
`endif
                        end else begin
                            load_err <= 1'b1;
`ifdef KEY_LOCKOUT_EN
                            fail_cnt <= fail_cnt + FAIL_W'(1);
                            state    <= lock_c ? LOCKOUT : ERROR;
`else
                            state    <= ERROR;
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_stream_loader.sv
// Self-checking bench for key_stream_loader: queue-based reference model plus directed loads.
module tb_key_stream_loader;
    localparam int unsigned KEY_W    = 16;
    localparam int unsigned CHUNK_W  = 8;
    localparam int unsigned NCHUNK   = KEY_W / CHUNK_W;
    localparam int unsigned MAX_FAIL = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_start;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             load_err;
    logic             busy;

    key_stream_loader_if #(.CHUNK_W(CHUNK_W)) bus ();

    key_stream_loader #(
        .KEY_W    (KEY_W),
        .CHUNK_W  (CHUNK_W),
        .MAX_FAIL (MAX_FAIL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .stream     (bus),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .load_err   (load_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: collects accepted chunks in a queue and decides the
    // outcome once the key chunks and the checksum have all arrived.
    logic [CHUNK_W-1:0] rx_q[$];
    bit                 m_loading = 1'b0;
    bit                 m_locked  = 1'b0;
    int                 m_fails   = 0;
    logic [KEY_W-1:0]   m_key     = '0;
    bit                 m_valid   = 1'b0;
    bit                 m_err     = 1'b0;

    always @(posedge clk) begin
        logic [CHUNK_W-1:0] sum;
        logic [KEY_W-1:0]   k;
        if (!rst_n) begin
            m_loading = 1'b0;
            m_locked  = 1'b0;
            m_fails   = 0;
            rx_q.delete();
            m_key     = '0;
            m_valid   = 1'b0;
            m_err     = 1'b0;
            checking  = 1'b1;
        end else if (load_start && !m_locked) begin
            m_loading = 1'b1;
            rx_q.delete();
            m_key     = '0;
            m_valid   = 1'b0;
            m_err     = 1'b0;
        end else if (m_loading && bus.in_valid) begin
            rx_q.push_back(bus.in_data);
            if (rx_q.size() == NCHUNK + 1) begin
                sum = '0;
                k   = '0;
                for (int i = 0; i < int'(NCHUNK); i++) begin
                    sum = sum ^ rx_q[i];
                    k   = (k << CHUNK_W) | KEY_W'(rx_q[i]);
                end
                m_loading = 1'b0;
                if (sum == rx_q[NCHUNK]) begin
                    m_key   = k;
                    m_valid = 1'b1;
                    m_fails = 0;
                end else begin
                    m_err = 1'b1;
`ifdef KEY_LOCKOUT_EN
                    m_fails++;
                    if (m_fails >= int'(MAX_FAIL)) m_locked = 1'b1;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("key_out",   32'(key_out),     32'(m_key));
            check("key_valid", 32'(key_valid),   32'(m_valid));
            check("load_err",  32'(load_err),    32'(m_err));
            check("in_ready",  32'(bus.in_ready), 32'(m_loading));
            check("busy",      32'(busy),        32'(m_loading));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [CHUNK_W-1:0] d, input int gap);
        bus.in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            bus.in_data = 8'hEE;
            step();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pulse_start();
        send(a, 0);
        send(b, 0);
        send(c, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        step();
        step();
        rst_n = 1'b1;
        check("lit_reset_key",  32'(key_out), 32'h0);
        check("lit_reset_busy", 32'(busy),    32'h0);

        // Good load
        do_load(8'hA5, 8'h3C, 8'h99);
        check("lit_good_key",   32'(key_out),   32'hA53C);
        check("lit_good_valid", 32'(key_valid), 32'h1);
        check("lit_good_err",   32'(load_err),  32'h0);

        // Chunks offered while ACTIVE are ignored
        send(8'h55, 0);
        send(8'h66, 2);
        check("lit_active_hold", 32'(key_out), 32'hA53C);

        // Bad checksum
        do_load(8'hA5, 8'h3C, 8'h98);
        check("lit_bad_err",   32'(load_err),  32'h1);
        check("lit_bad_key",   32'(key_out),   32'h0);
        check("lit_bad_valid", 32'(key_valid), 32'h0);

        // Stalled good load out of ERROR
        pulse_start();
        check("lit_err_cleared", 32'(load_err), 32'h0);
        send(8'hA5, 3);
        send(8'h3C, 1);
        send(8'h99, 4);
        check("lit_stall_key", 32'(key_out), 32'hA53C);

        // Restart coincident with a handshake drops that chunk
        pulse_start();
        send(8'hA5, 0);
        load_start   = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        step();
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        check("lit_collide_key", 32'(key_out), 32'h1122);

        // Reset mid-load
        pulse_start();
        send(8'hA5, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("lit_rst_busy",  32'(busy),         32'h0);
        check("lit_rst_ready", 32'(bus.in_ready), 32'h0);
        check("lit_rst_key",   32'(key_out),      32'h0);
        do_load(8'hA5, 8'h3C, 8'h99);
        check("lit_post_rst_key", 32'(key_out), 32'hA53C);

        // Reload while ACTIVE
        pulse_start();
        check("lit_reload_valid", 32'(key_valid), 32'h0);
        check("lit_reload_key",   32'(key_out),   32'h0);
        send(8'h0F, 0);
        send(8'hF0, 2);
        send(8'hFF, 0);
        check("lit_reload_new_key", 32'(key_out), 32'h0FF0);

`ifdef KEY_LOCKOUT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < int'(MAX_FAIL); i++) begin
            do_load(8'hA5, 8'h3C, 8'h98);
        end
        do_load(8'hA5, 8'h3C, 8'h99);
        check("lit_lock_key", 32'(key_out),  32'h0);
        check("lit_lock_err", 32'(load_err), 32'h1);
        check("lit_lock_busy", 32'(busy),    32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        do_load(8'hA5, 8'h3C, 8'h99);
        check("lit_unlock_key", 32'(key_out), 32'hA53C);
`endif

        step();
        step();
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_stream_loader.md
Name: key_stream_loader

Overview:
- Sequential key-delivery front end for logic-locked netlists.
- Receives a key as a stream of CHUNK_W-bit chunks on a valid/ready handshake, followed by one XOR checksum chunk.
- Assembles the chunks into a KEY_W-bit register and verifies the checksum.
- Drives the locked combinational core's key inputs only after the checksum verifies; otherwise drives all-zero key (wrong key, corrupted outputs).

Parameters:
- KEY_W, 16, total key width in bits; must be an integer multiple of CHUNK_W.
- CHUNK_W, 8, width of one stream chunk and of the checksum.
- MAX_FAIL, 3, failed-load count that triggers lockout (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- load_start  input  1  single-cycle pulse; begins or restarts a key load.
- in_valid  input  1  chunk valid.
- in_data  input  CHUNK_W  key chunk or checksum chunk.
- in_ready  output  1  chunk accepted when in_valid && in_ready.
- key_out  output  KEY_W  key to the locked netlist key inputs; 0 unless key_valid.
- key_valid  output  1  verified key is applied.
- load_err  output  1  sticky checksum-mismatch flag.
- busy  output  1  high in LOAD and CHK.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces, on the next cycle:
  - state=IDLE; shift register, chunk counter and checksum accumulator cleared.
  - key_out=0, key_valid=0, load_err=0, in_ready=0, busy=0.
  - Reset mid-load abandons the load; no partial key is ever exposed.
- NCHUNK = KEY_W/CHUNK_W. Chunk counter width = clog2(NCHUNK+1).
- States: IDLE, LOAD, CHK, ACTIVE, ERROR.
- IDLE -> LOAD on load_start. Entry into LOAD (from any state):
  - clears counter, accumulator and shift register;
  - drops key_valid, clears load_err, zeroes key_out;
  - all take effect the cycle after the pulse.
- LOAD:
  - in_ready=1.
  - Each accepted chunk shifts in MSB-first: the first chunk ends in key bits [KEY_W-1 -: CHUNK_W].
  - Each accepted chunk is XORed into the accumulator; counter increments.
  - After the NCHUNK-th accepted chunk -> CHK.
- CHK:
  - in_ready=1.
  - The accepted chunk is the checksum, compared to the accumulator.
  - Equal -> ACTIVE: key_valid=1 and key_out=assembled key on the following cycle (1-cycle latency from checksum acceptance).
  - Unequal -> ERROR.
- ACTIVE:
  - in_ready=0; key held indefinitely.
  - Only load_start or reset leave this state.
- ERROR:
  - load_err=1, key_out=0, key_valid=0, in_ready=0.
  - Exits only on load_start (-> LOAD) or reset.
- load_start in the same cycle as an in_valid handshake: the restart wins and the chunk is discarded (not counted, not XORed).
- in_valid while in_ready=0 is ignored. in_data is don't-care when in_valid=0.
- Stalls (in_valid low) may last any length; no timeout.
- key_out is registered; it never reflects the shift register while busy.

Optional Feature:
- Macro: KEY_LOCKOUT_EN.
- With the macro defined:
  - A saturating fail counter (width clog2(MAX_FAIL+1)) increments on each CHK->ERROR transition.
  - When the counter reaches MAX_FAIL, the block enters a terminal LOCKOUT state: load_start is ignored, key_out=0, load_err=1.
  - Only reset clears LOCKOUT.
  - A successful verify (entry to ACTIVE) clears the fail counter.
- Without the macro: no fail counter, no LOCKOUT state; ERROR always accepts load_start; MAX_FAIL is unused.

Decomposition:
- Shared package `key_loader_pkg`:
  - state enum: IDLE, LOAD, CHK, ACTIVE, ERROR, LOCKOUT;
  - function computing NCHUNK;
  - checksum-width constant.
- One natural sub-module, `key_chunk_shifter`: shift register plus XOR accumulator plus chunk counter, with clear/shift-enable inputs and done/acc outputs.
- The top level holds the FSM, output registers and the optional lockout logic.

Test Plan:
- Good load (KEY_W=16, CHUNK_W=8): load_start, chunks 0xA5, 0x3C, checksum 0x99 -> key_valid=1 and key_out=0xA53C one cycle after checksum acceptance; load_err=0.
- Bad checksum: same chunks, checksum 0x98 -> ERROR, load_err=1, key_out=0x0000, key_valid=0.
- Stalls and collision:
  - in_valid toggling with gaps between 0xA5/0x3C/0x99 -> same result as the good load.
  - load_start coincident with the 0x3C handshake -> 0x3C dropped; reload 0x11, 0x22, 0x33 -> key_out=0x1122.
- Reset mid-load: after 0xA5 accepted, rst_n=0 for one cycle -> all outputs 0 and state IDLE; a subsequent full good load succeeds.
- Reload while ACTIVE: with 0xA53C active, load_start -> key_valid=0 and key_out=0 the next cycle; load 0x0F, 0xF0, 0xFF -> key_out=0x0FF0.
- KEY_LOCKOUT_EN, MAX_FAIL=3:
  - three bad loads -> LOCKOUT; a following good load is ignored and key_out stays 0;
  - reset, then good load -> key_out=0xA53C.
